// File: rtl/l4_layer_writer_if.sv
// Host stream, memory write port and display handshake for l4_layer_writer.
interface l4_layer_writer_if #(
    parameter int DW = 32,
    parameter int AW = 14
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_sof;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          disp_frame_end;
    logic          disp_bank;
    logic          swap;
    logic          sof_err;

    // Host / display side
    modport master (
        output in_valid, in_data, in_sof, disp_frame_end,
        input  in_ready, wr_en, wr_addr, wr_data, disp_bank, swap, sof_err
    );

    // Writer side
    modport slave (
        input  in_valid, in_data, in_sof, disp_frame_end,
        output in_ready, wr_en, wr_addr, wr_data, disp_bank, swap, sof_err
    );
endinterface

// File: rtl/l4_layer_writer.sv
// Write-side sequencer for the double-buffered layered display buffer.
// Fills the bank the display is not reading, then swaps on display frame end.
module l4_layer_writer #(
    parameter int NLBITS  = 3,
    parameter int NLAYERS = 8,
    parameter int NRBITS  = 5,
    parameter int NROWS   = 32,
    parameter int NCBITS  = 5,
    parameter int NCOLS   = 32,
    parameter int DW      = 32
) (
    input logic              clk,
    input logic              resetn,
    l4_layer_writer_if.slave bus
);
    localparam int AW = 1 + NLBITS + NRBITS + NCBITS;
    localparam logic [NLBITS-1:0] LAYER_MAX = NLBITS'(NLAYERS - 1);
    localparam logic [NRBITS-1:0] ROW_MAX   = NRBITS'(NROWS - 1);
    localparam logic [NCBITS-1:0] COL_MAX   = NCBITS'(NCOLS - 1);

    typedef enum logic [1:0] {IDLE, WRITE, PENDING} state_t;

    state_t            state_q, state_d;
    logic [NLBITS-1:0] layer_q, layer_d;
    logic [NRBITS-1:0] row_q, row_d;
    logic [NCBITS-1:0] col_q, col_d;
    logic              bank_q, bank_d;
    logic              wr_en_q, wr_en_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [DW-1:0]     wr_data_q, wr_data_d;
    logic              swap_q, swap_d;
    logic              sof_err_q, sof_err_d;

    logic              ready;
    logic              accept;
    logic [NLBITS-1:0] base_layer;
    logic [NRBITS-1:0] base_row;
    logic [NCBITS-1:0] base_col;
    logic              frame_last;

    assign ready  = (state_q != PENDING);
    assign accept = bus.in_valid && ready;

    // A start-of-frame word always restarts addressing at (0,0,0).
    assign base_layer = bus.in_sof ? '0 : layer_q;
    assign base_row   = bus.in_sof ? '0 : row_q;
    assign base_col   = bus.in_sof ? '0 : col_q;
    assign frame_last = (base_layer == LAYER_MAX) && (base_row == ROW_MAX) &&
                        (base_col == COL_MAX);

    // Next-state, address counters and registered write/pulse outputs
    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        row_d     = row_q;
        col_d     = col_q;
        bank_d    = bank_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        swap_d    = 1'b0;
        sof_err_d = 1'b0;
        case (state_q)
            IDLE, WRITE: begin
                if (accept && (state_q == WRITE || bus.in_sof)) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {~bank_q, base_layer, base_row, base_col};
                    wr_data_d = bus.in_data;
                    sof_err_d = (state_q == WRITE) && bus.in_sof;
                    if (frame_last) begin
                        layer_d = '0;
                        row_d   = '0;
                        col_d   = '0;
                        state_d = PENDING;
                    end else begin
                        state_d = WRITE;
                        if (base_col == COL_MAX) begin
                            col_d = '0;
                            if (base_row == ROW_MAX) begin
                                row_d   = '0;
                                layer_d = base_layer + NLBITS'(1);
                            end else begin
                                row_d   = base_row + NRBITS'(1);
                                layer_d = base_layer;
                            end
                        end else begin
                            col_d   = base_col + NCBITS'(1);
                            row_d   = base_row;
                            layer_d = base_layer;
                        end
                    end
                end
            end
            PENDING: begin
                if (bus.disp_frame_end) begin
                    bank_d  = ~bank_q;
                    swap_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            layer_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
            bank_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            swap_q    <= 1'b0;
            sof_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            layer_q   <= layer_d;
            row_q     <= row_d;
            col_q     <= col_d;
            bank_q    <= bank_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            swap_q    <= swap_d;
            sof_err_q <= sof_err_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.disp_bank = bank_q;
    assign bus.swap      = swap_q;
    assign bus.sof_err   = sof_err_q;
endmodule

// File: tb/tb_l4_layer_writer.sv
// Self-checking bench for l4_layer_writer (2 layers x 2 rows x 4 cols).
module tb_l4_layer_writer;
    localparam int FRAME = 16;

    logic clk;
    logic resetn;

    l4_layer_writer_if #(.DW(32), .AW(5)) bus ();

    l4_layer_writer #(
        .NLBITS(1), .NLAYERS(2), .NRBITS(1), .NROWS(2),
        .NCBITS(2), .NCOLS(4), .DW(32)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: frame-linear word index, bank, in-frame and full flags
    bit          m_bank;
    bit          m_in_frame;
    bit          m_full;
    int          m_idx;
    logic        exp_wen, exp_swap, exp_serr;
    logic [31:0] exp_addr, exp_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bank = 0; m_in_frame = 0; m_full = 0; m_idx = 0;
    endtask

    task automatic model_edge(input logic v, input logic [31:0] d, input logic s, input logic f);
        exp_wen = 0; exp_swap = 0; exp_serr = 0;
        if (m_full) begin
            if (f) begin
                m_bank   = !m_bank;
                exp_swap = 1;
                m_full   = 0;
            end
        end else if (v) begin
            if (s) begin
                if (m_in_frame) exp_serr = 1;
                m_idx      = 0;
                m_in_frame = 1;
            end
            if (m_in_frame) begin
                exp_wen  = 1;
                exp_addr = 32'((m_bank ? 0 : FRAME) + m_idx);
                exp_data = d;
                m_idx++;
                if (m_idx == FRAME) begin
                    m_idx      = 0;
                    m_in_frame = 0;
                    m_full     = 1;
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic s, input logic f);
        @(negedge clk);
        bus.in_valid       = v;
        bus.in_data        = d;
        bus.in_sof         = s;
        bus.disp_frame_end = f;
        #1 chk("in_ready", {31'b0, bus.in_ready}, {31'b0, !m_full});
        @(posedge clk);
        model_edge(v, d, s, f);
        #1;
        chk("wr_en", {31'b0, bus.wr_en}, {31'b0, exp_wen});
        chk("swap", {31'b0, bus.swap}, {31'b0, exp_swap});
        chk("sof_err", {31'b0, bus.sof_err}, {31'b0, exp_serr});
        chk("disp_bank", {31'b0, bus.disp_bank}, {31'b0, m_bank});
        if (exp_wen) begin
            chk("wr_addr", {27'b0, bus.wr_addr}, exp_addr);
            chk("wr_data", bus.wr_data, exp_data);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_wr_en", {31'b0, bus.wr_en}, 32'd0);
        chk("rst_wr_addr", {27'b0, bus.wr_addr}, 32'd0);
        chk("rst_wr_data", bus.wr_data, 32'd0);
        chk("rst_swap", {31'b0, bus.swap}, 32'd0);
        chk("rst_sof_err", {31'b0, bus.sof_err}, 32'd0);
        chk("rst_disp_bank", {31'b0, bus.disp_bank}, 32'd0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid = 0; bus.in_data = '0; bus.in_sof = 0; bus.disp_frame_end = 0;
        resetn = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 resetn = 1;
        check_reset_state();

        // 1: contiguous frame 0..15 into bank 1, then pending (no accepts)
        for (int i = 0; i < FRAME; i++) step(1, 32'(i), i == 0, 0);
        step(0, 0, 0, 0);
        step(1, 32'h99, 0, 0);

        // 2: display frame end swaps; next frame (frame end on last word ignored)
        step(0, 0, 0, 1);
        for (int i = 0; i < FRAME; i++) step(1, 32'(100 + i), i == 0, i == FRAME - 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);

        // 3: words without sof in IDLE are discarded, frame end ignored in IDLE
        step(1, 32'hA0, 0, 0);
        step(1, 32'hA1, 0, 1);
        step(1, 32'hA2, 0, 0);
        for (int i = 0; i < FRAME; i++) step(1, 32'(200 + i), i == 0, 0);
        step(0, 0, 0, 1);

        // 4: sof on word 6 restarts the frame and flags sof_err
        for (int i = 0; i < 6; i++) step(1, 32'(300 + i), i == 0, 0);
        for (int i = 0; i < FRAME; i++) step(1, 32'(400 + i), i == 0, 0);
        step(0, 0, 0, 1);

        // 5: random valid gaps, random sof and frame-end pulses
        for (int n = 0; n < 250; n++) begin
            logic v, s, f;
            v = ($urandom_range(0, 99) >= 30);
            s = m_in_frame ? ($urandom_range(0, 99) < 3) : ($urandom_range(0, 99) < 70);
            f = ($urandom_range(0, 99) < 20);
            step(v, $urandom, s, f);
        end

        // 6: asynchronous reset mid-frame after word 8 has been written
        if (m_full) step(0, 0, 0, 1);
        for (int i = 0; i < 9; i++) step(1, 32'(500 + i), i == 0, 0);
        #2 resetn = 0;
        #1;
        chk("async_wr_en", {31'b0, bus.wr_en}, 32'd0);
        chk("async_swap", {31'b0, bus.swap}, 32'd0);
        chk("async_sof_err", {31'b0, bus.sof_err}, 32'd0);
        chk("async_disp_bank", {31'b0, bus.disp_bank}, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #2 resetn = 1;
        check_reset_state();
        for (int i = 0; i < FRAME; i++) begin
            step(1, 32'(600 + i), i == 0, 0);
            if (i == 0) chk("post_reset_addr", {27'b0, bus.wr_addr}, 32'd16);
        end
        step(0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
